uart_insn_loader: RTL and testbench
===================================

// Module: uart_insn_loader
// PURPOSE
//   Boot loader upstream of the SoC instruction memory. Receives a program image over
//   UART (8N1), packs the bytes into 32-bit words and writes them through the insn-memory
//   write port (wen/waddr/insn). Holds the CPU core in reset until the load completes,
//   then releases it. Re-arms for a new image when the core signals ebreak.
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  system clock frequency
//   BAUD         115_200     UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide)
//   ADDR_WIDTH   12          insn memory byte-address width
//   MAX_WORDS    1024        largest accepted image (2**ADDR_WIDTH/4)
// PORTS
//   clk_i             in   1           system clock
//   rstn_i            in   1           async active-low reset
//   uart_rx_i         in   1           UART serial input, idle high, asynchronous
//   ebreak_i          in   1           core halted; level, sampled each cycle
//   insn_mem_wen_o    out  1           insn memory write enable, 1-cycle pulse per word
//   insn_mem_waddr_o  out  ADDR_WIDTH  byte address, word-aligned (word_idx*4)
//   insn_o            out  32          instruction word {b3,b2,b1,b0}, little-endian
//   cpu_rstn_o        out  1           core reset, active-low; high only in DONE
//   load_done_o       out  1           image loaded, core running
//   load_err_o        out  1           load aborted (framing/length/checksum)
// BEHAVIOUR
//   Reset: every output 0 (cpu_rstn_o low, i.e. core held); FSM in IDLE; word_idx 0.
//   Reset mid-load: async abort, partial image is left in memory, next load starts at 0.
//   UART RX: 2-flop synchroniser; a falling edge in idle starts a frame; the start bit is
//     re-checked at CLKS_PER_BIT/2 (if high -> glitch, back to idle, no byte). Data bits
//     are sampled at the mid-bit, LSB first. A stop bit sampled 0 -> framing error.
//     Emits byte_vld as a 1-cycle pulse with byte_data.
//   Frame: 0xA5 sync, LEN_LO, LEN_HI (word count N), then 4*N data bytes.
//   FSM: IDLE -(byte 0xA5)-> LEN_LO -> LEN_HI -> (N==0: DONE | N>MAX_WORDS: ERR | else DATA)
//     DATA: byte_cnt 0..3 collects bytes; on the 4th byte_vld, in the next cycle:
//       wen=1, waddr=word_idx*4, insn=packed word; word_idx++.
//       After word N-1 is written -> DONE.
//     IDLE ignores any byte other than 0xA5.
//   DONE: cpu_rstn_o=1 and load_done_o=1, both registered (1 cycle after entering DONE).
//     Received bytes are ignored. ebreak_i=1 -> IDLE; cpu_rstn_o and done drop the
//     next cycle and word_idx clears.
//   ERR: load_err_o=1, core held in reset. A received 0xA5 -> LEN_LO, err clears.
//   Framing error in any state except DONE -> ERR. In IDLE, only if it would start a frame.
//   wen is never asserted outside DATA. The address wraps modulo 2**ADDR_WIDTH; this is
//     unreachable because N<=MAX_WORDS.
// CONFIGURATION
//   UART_LOADER_CHECKSUM_EN defined: a CSUM state follows the last word (or LEN_HI when
//     N==0). One byte is expected, equal to the XOR of all data bytes. Match -> DONE.
//     Mismatch -> ERR, and memory stays written.
//   Not defined: no checksum byte; the last word goes straight to DONE.
// STRUCTURE
//   Package uart_loader_pkg: FSM state encoding, SYNC_BYTE=8'hA5, CLKS_PER_BIT function.
//   Sub-module uart_rx (synchroniser + bit-timing counter + shift reg;
//     outputs byte_vld, byte_data, frame_err).
//   The top level holds the frame FSM, byte/word counters, pack register and
//     output registers.
// TESTING (bench: CLK_FREQ_HZ=1_000_000, BAUD=100_000 -> 10 clks/bit)
//   A5 02 00 | 13 00 00 00 | 73 00 10 00 -> wen pulses:
//     addr 0x000 data 0x00000013, then addr 0x004 data 0x00100073.
//     Then cpu_rstn_o=1 and load_done_o=1.
//   A5 00 00 -> no wen; DONE reached; with CHECKSUM_EN, byte 00 is needed first.
//   A5 01 04 (N=1025) -> load_err_o=1 with no wen.
//     Then A5 01 00 + 1 word -> err clears and DONE.
//   Stop bit forced 0 during the 3rd data byte -> ERR, cpu_rstn_o stays 0,
//     and word_idx is not advanced.
//   Start-bit glitch of 3 clks on uart_rx_i -> no byte_vld, FSM unchanged.
//   In DONE, raise ebreak_i -> cpu_rstn_o=0 next cycle, IDLE. A new image reloads from 0x000.
//   rstn_i low mid-DATA -> all outputs 0 immediately; next load starts at 0x000.
//   CHECKSUM_EN: A5 01 00 01 02 03 04 04 -> DONE. Last byte 05 -> ERR.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants for the UART instruction loader
// Contents: loader FSM state encoding, image sync byte, UART bit-period helper.
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with synchroniser and mid-bit sampling
// Ports:
//   clk_i, rstn_i  clock, async active-low reset
//   rx_i           asynchronous serial input, idle high
//   byte_vld       1-cycle pulse, byte_data holds the received byte
//   byte_data      last received byte
//   frame_err      1-cycle pulse when a started frame has a low stop bit
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    rstate;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // Synchroniser resets to the idle level so reset release is not seen as a start edge.
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rstate    <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rstate)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rstate <= RX_START;
                        cnt    <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_END) begin
                        // Mid start bit: a high line means the edge was a glitch.
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rstate <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == BIT_END) begin
                        cnt    <= '0;
                        rstate <= RX_IDLE;
                        if (rx_sync) begin
                            byte_vld  <= 1'b1;
                            byte_data <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_insn_loader.sv
// rtl/uart_insn_loader.sv - UART boot loader writing a program image into insn memory
// Frame: A5, LEN_LO, LEN_HI (word count N), 4*N little-endian data bytes.
// Optional macro UART_LOADER_CHECKSUM_EN: a trailing XOR-of-data checksum byte is required.
// Ports:
//   clk_i, rstn_i     clock, async active-low reset
//   uart_rx_i         UART serial input (8N1, idle high)
//   ebreak_i          core halted; re-arms the loader from DONE
//   insn_mem_wen_o    1-cycle write pulse per packed word
//   insn_mem_waddr_o  word-aligned byte address
//   insn_o            packed instruction word {b3,b2,b1,b0}
//   cpu_rstn_o        core reset, released only while DONE
//   load_done_o       image loaded, core running
//   load_err_o        load aborted (framing/length/checksum)
module uart_insn_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_WORDS   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  uart_rx_i,
    input  logic                  ebreak_i,
    output logic                  insn_mem_wen_o,
    output logic [ADDR_WIDTH-1:0] insn_mem_waddr_o,
    output logic [31:0]           insn_o,
    output logic                  cpu_rstn_o,
    output logic                  load_done_o,
    output logic                  load_err_o
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

`ifdef UART_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER_LAST = ST_CSUM;
`else
    localparam logic [2:0] ST_AFTER_LAST = ST_DONE;
`endif

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .rx_i      (uart_rx_i),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    logic [2:0]  state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] len, len_full;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] pack;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign len_full = {byte_data, len_lo};

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld && byte_data == SYNC_BYTE) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld) begin
                    if (len_full == 16'd0) state_next = ST_AFTER_LAST;
                    else if (len_full > 16'(MAX_WORDS)) state_next = ST_ERR;
                    else state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld && byte_cnt == 2'd3 && word_idx == len - 16'd1)
                    state_next = ST_AFTER_LAST;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld) state_next = (byte_data == csum) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                if (ebreak_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= ST_IDLE;
            len_lo           <= '0;
            len              <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            pack             <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
            insn_mem_wen_o   <= 1'b0;
            insn_mem_waddr_o <= '0;
            insn_o           <= '0;
            cpu_rstn_o       <= 1'b0;
            load_done_o      <= 1'b0;
            load_err_o       <= 1'b0;
        end else begin
            state          <= state_next;
            insn_mem_wen_o <= 1'b0;
            // Release is delayed one cycle after entering DONE; leaving DONE drops it at once.
            cpu_rstn_o     <= (state == ST_DONE) && (state_next == ST_DONE);
            load_done_o    <= (state == ST_DONE) && (state_next == ST_DONE);
            load_err_o     <= (state_next == ST_ERR);

            // Every accepted sync byte starts a fresh image at word 0.
            if (state != ST_LEN_LO && state_next == ST_LEN_LO) begin
                word_idx <= '0;
                byte_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == ST_DONE && ebreak_i) word_idx <= '0;

            if (byte_vld) begin
                case (state)
                    ST_LEN_LO: len_lo <= byte_data;
                    ST_LEN_HI: len    <= len_full;
                    ST_DATA: begin
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        case (byte_cnt)
                            2'd0: pack[7:0]   <= byte_data;
                            2'd1: pack[15:8]  <= byte_data;
                            2'd2: pack[23:16] <= byte_data;
                            default: begin
                                insn_mem_wen_o   <= 1'b1;
                                insn_mem_waddr_o <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                                insn_o           <= {byte_data, pack};
                                word_idx         <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_insn_loader.sv
// tb/tb_uart_insn_loader.sv - self-checking bench for uart_insn_loader (10 clks/bit)
module tb_uart_insn_loader;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        uart_rx = 1'b1;
    logic        ebreak = 1'b0;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] insn;
    logic        cpu_rstn;
    logic        load_done;
    logic        load_err;

    uart_insn_loader #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .ADDR_WIDTH  (12),
        .MAX_WORDS   (1024)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .uart_rx_i        (uart_rx),
        .ebreak_i         (ebreak),
        .insn_mem_wen_o   (wen),
        .insn_mem_waddr_o (waddr),
        .insn_o           (insn),
        .cpu_rstn_o       (cpu_rstn),
        .load_done_o      (load_done),
        .load_err_o       (load_err)
    );

    always #5 clk = ~clk;

    logic [11:0] aq[$];
    logic [31:0] dq[$];
    always @(negedge clk) begin
        if (wen) begin
            aq.push_back(waddr);
            dq.push_back(insn);
        end
    end

    typedef logic [0:11][7:0] bytes_t;
    typedef struct {
        bytes_t      bytes;
        int          nbytes;
        logic        has_csum;
        logic [7:0]  csum;
        int          nwen;
        logic [31:0] data0;
        logic [31:0] data1;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wbase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word_image(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        send_byte(b3, 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2 ^ b3, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        uart_rx = 1'b1;
        ebreak  = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        wbase = aq.size();
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_words(input string name, input int nwen,
                               input logic [31:0] d0, input logic [31:0] d1);
        int got;
        got = aq.size() - wbase;
        check({name, " wen_count"}, 32'(got), 32'(nwen));
        for (int i = 0; i < nwen && i < got; i++) begin
            check({name, " waddr"}, 32'(aq[wbase + i]), 32'(i * 4));
            check({name, " insn"}, dq[wbase + i], (i == 0) ? d0 : d1);
        end
    endtask

    task automatic check_status(input string name, input logic done, input logic err);
        check({name, " load_done"}, 32'(load_done), 32'(done));
        check({name, " cpu_rstn"}, 32'(cpu_rstn), 32'(done));
        check({name, " load_err"}, 32'(load_err), 32'(err));
    endtask

    initial begin
        vecs[0] = '{bytes: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h73, 8'h00, 8'h10, 8'h00, 8'h00},
                    nbytes: 11, has_csum: 1'b1, csum: 8'h70, nwen: 2,
                    data0: 32'h0000_0013, data1: 32'h0010_0073, done: 1'b1, err: 1'b0};
        vecs[1] = '{bytes: {8'hA5, 8'h00, 8'h00, 72'h0},
                    nbytes: 3, has_csum: 1'b1, csum: 8'h00, nwen: 0,
                    data0: 32'h0, data1: 32'h0, done: 1'b1, err: 1'b0};
        vecs[2] = '{bytes: {8'hA5, 8'h01, 8'h04, 72'h0},
                    nbytes: 3, has_csum: 1'b0, csum: 8'h00, nwen: 0,
                    data0: 32'h0, data1: 32'h0, done: 1'b0, err: 1'b1};
        vecs[3] = '{bytes: {8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 40'h0},
                    nbytes: 7, has_csum: 1'b1, csum: 8'h22, nwen: 1,
                    data0: 32'hEFBE_ADDE, data1: 32'h0, done: 1'b1, err: 1'b0};
        vecs[4] = '{bytes: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03,
                            8'h04, 24'h0},
                    nbytes: 9, has_csum: 1'b1, csum: 8'h04, nwen: 1,
                    data0: 32'h0403_0201, data1: 32'h0, done: 1'b1, err: 1'b0};

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        check("reset wen", 32'(wen), 32'd0);
        check("reset waddr", 32'(waddr), 32'd0);
        check("reset insn", insn, 32'd0);
        check_status("reset", 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[i], 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
            if (vecs[v].has_csum) send_byte(vecs[v].csum, 1'b0);
`endif
            settle();
            check_words($sformatf("vec%0d", v), vecs[v].nwen, vecs[v].data0, vecs[v].data1);
            check_status($sformatf("vec%0d", v), vecs[v].done, vecs[v].err);
        end

        // Oversized length, then a valid image clears the error.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        settle();
        check_status("len_err", 1'b0, 1'b1);
        send_word_image(8'h13, 8'h00, 8'h00, 8'h00);
        settle();
        check_words("len_recover", 1, 32'h0000_0013, 32'h0);
        check_status("len_recover", 1'b1, 1'b0);

        // Framing error on the 3rd data byte, then reload from word 0.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        settle();
        check_words("frame_err", 0, 32'h0, 32'h0);
        check_status("frame_err", 1'b0, 1'b1);
        send_word_image(8'h44, 8'h55, 8'h66, 8'h77);
        settle();
        check_words("frame_recover", 1, 32'h7766_5544, 32'h0);
        check_status("frame_recover", 1'b1, 1'b0);

        // 3-clock start glitch in the middle of a word must not inject a byte.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h44, 1'b0);
`endif
        settle();
        check_words("glitch", 1, 32'h4433_2211, 32'h0);
        check_status("glitch", 1'b1, 1'b0);

        // ebreak in DONE drops the core reset on the next edge and re-arms at 0x000.
        ebreak = 1'b1;
        @(negedge clk);
        check("ebreak cpu_rstn", 32'(cpu_rstn), 32'd0);
        check("ebreak load_done", 32'(load_done), 32'd0);
        ebreak = 1'b0;
        repeat (3) @(negedge clk);
        wbase = aq.size();
        send_word_image(8'h93, 8'h00, 8'h00, 8'h00);
        settle();
        check_words("reload", 1, 32'h0000_0093, 32'h0);
        check_status("reload", 1'b1, 1'b0);

        // Async reset in the middle of DATA clears outputs at once.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h55, 1'b0);
        check_words("pre_reset", 1, 32'h1122_3344, 32'h0);
        rstn = 1'b0;
        #1;
        check("midreset wen", 32'(wen), 32'd0);
        check("midreset waddr", 32'(waddr), 32'd0);
        check("midreset insn", insn, 32'd0);
        check_status("midreset", 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        wbase = aq.size();
        send_word_image(8'h01, 8'h00, 8'h00, 8'h00);
        settle();
        check_words("post_reset", 1, 32'h0000_0001, 32'h0);
        check_status("post_reset", 1'b1, 1'b0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Wrong checksum: memory already written, load reports an error.
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        settle();
        check_words("csum_bad", 1, 32'h0403_0201, 32'h0);
        check_status("csum_bad", 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
